// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / divide unit with HI/LO registers.
// MULT uses a 32-step radix-2 shift-add on operand magnitudes. DIV uses a
// 32-step restoring division on magnitudes. Sign correction is applied in a
// single FIX cycle.
// Configuration macro MDU_DIV_EN: when defined, the divider is built. When it is
// undefined, the divider is absent. In that build an accepted DIV leaves HI/LO
// unchanged and only pulses done.
module mult_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  Op,
   input  logic        Sign,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        done
);

   localparam int DATA_W = 32;

   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b01;
   localparam logic [1:0] OP_MTHI = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   // magnitude of an operand; unsigned operands pass through untouched
   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
      return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
   endfunction

   // conditional two's-complement negation used for sign correction
   function automatic logic [DATA_W-1:0] cneg32(input logic [DATA_W-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] cneg64(input logic [2*DATA_W-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic                sign_q, sign_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]   ma, mb;
   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] mul_next;
   logic [2*DATA_W-1:0] step_next;
   logic [2*DATA_W-1:0] prod;

   assign ma = mag(a_q, sign_q);
   assign mb = mag(b_q, sign_q);

   // Multiplier step: the upper half accumulates the multiplicand when the
   // current multiplier bit (acc[0]) is set. Then everything shifts right.
   assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, ma}) : {1'b0, acc_q[63:32]};
   assign mul_next = {mul_sum, acc_q[31:1]};
   assign prod     = cneg64(acc_q, sign_q & (a_q[31] ^ b_q[31]));

`ifdef MDU_DIV_EN
   logic                is_div_q, is_div_d;
   logic [DATA_W:0]     div_cand;
   logic                div_ge;
   logic [DATA_W-1:0]   div_diff;
   logic [2*DATA_W-1:0] div_next;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   // Restoring divider step: the upper half holds the partial remainder and the
   // lower half holds dividend bits being replaced by quotient bits. The
   // remainder is always below the divisor. So the 32-bit difference is exact
   // whenever the subtraction succeeds.
   assign div_cand = acc_q[63:31];
   assign div_ge   = (div_cand >= {1'b0, mb});
   assign div_diff = div_cand[31:0] - mb;
   assign div_next = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {div_cand[31:0], acc_q[30:0], 1'b0};

   // quotient truncates toward zero; remainder follows the dividend's sign
   assign quo_fix  = cneg32(acc_q[31:0],  sign_q & (a_q[31] ^ b_q[31]));
   assign rem_fix  = cneg32(acc_q[63:32], sign_q & a_q[31]);

   assign step_next = is_div_q ? div_next : mul_next;
`else
   assign step_next = mul_next;
`endif

   // next-state logic: request acceptance, iteration, and FIX-cycle writeback
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
`ifdef MDU_DIV_EN
      is_div_d = is_div_q;
`endif
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (Op)
                  OP_MULT: begin
                     state_d  = S_CALC;
                     busy_d   = 1'b1;
                     cnt_d    = 5'd0;
                     a_d      = A;
                     b_d      = B;
                     sign_d   = Sign;
`ifdef MDU_DIV_EN
                     is_div_d = 1'b0;
`endif
                     acc_d    = {32'd0, mag(B, Sign)};
                  end
                  OP_DIV: begin
`ifdef MDU_DIV_EN
                     state_d  = S_CALC;
                     busy_d   = 1'b1;
                     cnt_d    = 5'd0;
                     a_d      = A;
                     b_d      = B;
                     sign_d   = Sign;
                     is_div_d = 1'b1;
                     acc_d    = {32'd0, mag(A, Sign)};
`else
                     done_d   = 1'b1;
`endif
                  end
                  OP_MTHI: hi_d = A;
                  default: lo_d = A;
               endcase
            end
         end
         S_CALC: begin
            acc_d = step_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
`ifdef MDU_DIV_EN
            if (is_div_q) begin
               if (b_q == 32'd0) begin
                  hi_d = a_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end else begin
               hi_d = prod[63:32];
               lo_d = prod[31:0];
            end
`else
            hi_d = prod[63:32];
            lo_d = prod[31:0];
`endif
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // state, datapath and architectural registers; reset clears everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
`ifdef MDU_DIV_EN
         is_div_q <= 1'b0;
`endif
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
`ifdef MDU_DIV_EN
         is_div_q <= is_div_d;
`endif
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign HI   = hi_q;
   assign LO   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven vectors plus scoreboard for mult_div_unit,
// with hand sequences for ignored starts, back-to-back issue and reset abort.
// DIV expectations follow MDU_DIV_EN in the same way as the design.
module tb_mult_div_unit;

   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b01;
   localparam logic [1:0] OP_MTHI = 2'b10;
   localparam logic [1:0] OP_MTLO = 2'b11;
`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  op;
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  Op;
   logic        Sign;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        busy;
   logic        done;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   logic [31:0] cur_hi, cur_lo;
   vec_t tbl [15];

   mult_div_unit dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .Op   (Op),
      .Sign (Sign),
      .A    (A),
      .B    (B),
      .HI   (HI),
      .LO   (LO),
      .busy (busy),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // reference results from native wide arithmetic
   function automatic logic [63:0] model(input logic [1:0] op, input logic sg,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] hi, input logic [31:0] lo);
      logic signed [63:0] sp;
      logic signed [31:0] sa, sb_;
      sa  = a;
      sb_ = b;
      case (op)
         OP_MULT: begin
            if (sg) begin
               sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
               return sp;
            end
            return {32'd0, a} * {32'd0, b};
         end
         OP_DIV: begin
            if (!DIV_EN) return {hi, lo};
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (sg) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
               return {32'(sa % sb_), 32'(sa / sb_)};
            end
            return {a % b, a / b};
         end
         OP_MTHI: return {a, lo};
         default: return {hi, a};
      endcase
   endfunction

   // called at the first falling edge after acceptance; ends on the done cycle
   task automatic finish_op(input logic [1:0] op, input bit intrude);
      int          cyc;
      int          exp_cyc;
      bit          moved;
      exp_t        e;
      logic [31:0] h0, l0;
      h0    = HI;
      l0    = LO;
      moved = 1'b0;
      cyc   = 0;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_empty: got 0 entries, expected 1");
         e = {cur_hi, cur_lo};
      end else begin
         e = sb.pop_front();
      end
      if (op[1]) begin
         check("mt_hi", {32'd0, HI}, {32'd0, e.hi});
         check("mt_lo", {32'd0, LO}, {32'd0, e.lo});
         check("mt_busy", {63'd0, busy}, 64'd0);
         check("mt_done", {63'd0, done}, 64'd0);
      end else begin
         exp_cyc = (op == OP_DIV && !DIV_EN) ? 0 : 33;
         while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (intrude && cyc == 5) begin
               start = 1'b1; Op = OP_DIV; Sign = 1'b0; A = 32'd1; B = 32'd1;
            end else if (intrude && cyc == 6) begin
               start = 1'b1; Op = OP_MTHI; A = 32'h1111_1111;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            if (busy === 1'b1 && (HI !== h0 || LO !== l0)) moved = 1'b1;
         end
         start = 1'b0;
         check("busy_cycles", 64'(cyc), 64'(exp_cyc));
         check("done_high", {63'd0, done}, 64'd1);
         check("hold_while_busy", {63'd0, moved}, 64'd0);
         check("result_hi", {32'd0, HI}, {32'd0, e.hi});
         check("result_lo", {32'd0, LO}, {32'd0, e.lo});
      end
      cur_hi = e.hi;
      cur_lo = e.lo;
   endtask

   task automatic run_op(input logic [1:0] op, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit intrude);
      @(negedge clk);
      start = 1'b1; Op = op; Sign = sg; A = a; B = b;
      sb.push_back({ehi, elo});
      @(negedge clk);
      start = 1'b0; A = $urandom; B = $urandom; Sign = ~sg; Op = 2'($urandom);
      finish_op(op, intrude);
      if (!op[1]) begin
         @(negedge clk);
         check("done_one_cycle", {63'd0, done}, 64'd0);
      end
   endtask

   initial begin
      logic [63:0] r;
      logic [1:0]  rop;
      logic        rsg;
      logic [31:0] ra, rb;
      bit          seen;

      tbl[0]  = '{OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
      tbl[1]  = '{OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[2]  = '{OP_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      tbl[3]  = '{OP_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      tbl[4]  = '{OP_MULT, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
      tbl[5]  = '{OP_MULT, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
      tbl[6]  = '{OP_MTHI, 1'b0, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 32'h0000_0000};
      tbl[7]  = '{OP_MTLO, 1'b0, 32'hCAFE_F00D, 32'd0,         32'hDEAD_BEEF, 32'hCAFE_F00D};
      tbl[8]  = '{OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,
                  DIV_EN ? 32'hFFFF_FFFF : 32'hDEAD_BEEF, DIV_EN ? 32'hFFFF_FFFD : 32'hCAFE_F00D};
      tbl[9]  = '{OP_DIV,  1'b0, 32'd7,         32'd0,
                  DIV_EN ? 32'h0000_0007 : 32'hDEAD_BEEF, DIV_EN ? 32'hFFFF_FFFF : 32'hCAFE_F00D};
      tbl[10] = '{OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                  DIV_EN ? 32'h0000_0000 : 32'hDEAD_BEEF, DIV_EN ? 32'h8000_0000 : 32'hCAFE_F00D};
      tbl[11] = '{OP_DIV,  1'b1, 32'd100,       32'hFFFF_FFF9,
                  DIV_EN ? 32'h0000_0002 : 32'hDEAD_BEEF, DIV_EN ? 32'hFFFF_FFF2 : 32'hCAFE_F00D};
      tbl[12] = '{OP_DIV,  1'b0, 32'hFFFF_FFFF, 32'h0000_0010,
                  DIV_EN ? 32'h0000_000F : 32'hDEAD_BEEF, DIV_EN ? 32'h0FFF_FFFF : 32'hCAFE_F00D};
      tbl[13] = '{OP_DIV,  1'b1, 32'h1234_5678, 32'd0,
                  DIV_EN ? 32'h1234_5678 : 32'hDEAD_BEEF, DIV_EN ? 32'hFFFF_FFFF : 32'hCAFE_F00D};
      tbl[14] = '{OP_DIV,  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                  DIV_EN ? 32'hFFFF_FFFE : 32'hDEAD_BEEF, DIV_EN ? 32'h0000_000E : 32'hCAFE_F00D};

      rst_n = 1'b1; start = 1'b0; Op = 2'b00; Sign = 1'b0; A = '0; B = '0;
      cur_hi = '0; cur_lo = '0;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_hi",   {32'd0, HI}, 64'd0);
      check("reset_lo",   {32'd0, LO}, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      rst_n = 1'b1;

      // table vectors
      for (int i = 0; i < 15; i++) begin
         run_op(tbl[i].op, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b0);
      end

      // random MULT/DIV checked against the native-arithmetic model
      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 1));
         rsg = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
         r   = model(rop, rsg, ra, rb, cur_hi, cur_lo);
         run_op(rop, rsg, ra, rb, r[63:32], r[31:0], 1'b0);
      end

      // DIV and MTHI requested mid-MULT must be ignored
      run_op(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);

      // a new MULT issued in the done cycle is accepted
      @(negedge clk);
      start = 1'b1; Op = OP_MULT; Sign = 1'b0; A = 32'd3; B = 32'd4;
      sb.push_back({32'd0, 32'd12});
      @(negedge clk);
      start = 1'b0;
      finish_op(OP_MULT, 1'b0);
      start = 1'b1; Op = OP_MULT; Sign = 1'b1; A = 32'hFFFF_FFFE; B = 32'd5;
      sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF6});
      @(negedge clk);
      start = 1'b0;
      finish_op(OP_MULT, 1'b0);
      @(negedge clk);
      check("b2b_done_one_cycle", {63'd0, done}, 64'd0);

      // MTLO followed by DIV 9/3
      run_op(OP_MTLO, 1'b0, 32'h55, 32'd0, cur_hi, 32'h55, 1'b0);
      run_op(OP_DIV, 1'b0, 32'd9, 32'd3, DIV_EN ? 32'd0 : cur_hi, DIV_EN ? 32'd3 : 32'h55, 1'b0);

      // reset at cycle 10 of a MULT aborts it
      run_op(OP_MTHI, 1'b0, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, cur_lo, 1'b0);
      @(negedge clk);
      start = 1'b1; Op = OP_MULT; Sign = 1'b0; A = 32'd3; B = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_hi",   {32'd0, HI}, 64'd0);
      check("abort_lo",   {32'd0, LO}, 64'd0);
      cur_hi = '0; cur_lo = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      check("no_done_after_abort", {63'd0, seen}, 64'd0);
      check("abort_hi_held", {32'd0, HI}, 64'd0);
      check("abort_lo_held", {32'd0, LO}, 64'd0);

      // first start is taken on the first edge after reset release
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1; Op = OP_MULT; Sign = 1'b0; A = 32'd6; B = 32'd7;
      sb.push_back({32'd0, 32'd42});
      @(negedge clk);
      start = 1'b0;
      finish_op(OP_MULT, 1'b0);
      @(negedge clk);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request strobe, sampled on the rising edge.
REQ-004 SHALL have port Op, input, 2 bits: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-005 SHALL have port Sign, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned; applies to MULT and DIV only.
REQ-006 SHALL have ports A and B, input, 32 bits each: A is the multiplicand/dividend and the MTHI/MTLO source; B is the multiplier/divisor.
REQ-007 SHALL have ports HI and LO, output, 32 bits each: architectural registers, driven directly from flops.
REQ-008 SHALL have port busy, output, 1 bit: high while an iterative operation runs.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a completed MULT/DIV.

Function
REQ-010 SHALL accept a request only when start=1 and busy=0; start while busy=1 SHALL be ignored with no effect on state, HI or LO.
REQ-011 SHALL execute MTHI/MTLO in one edge (HI<=A or LO<=A), with no busy and no done.
REQ-012 SHALL implement FSM IDLE -> CALC (exactly 32 cycles) -> FIX (1 cycle) -> IDLE, entered on an accepted MULT/DIV.
REQ-013 SHALL latch A, B, Op and Sign at acceptance; later input changes SHALL NOT affect the result.
REQ-014 SHALL hold busy=1 for exactly 33 cycles, starting the cycle after acceptance.
REQ-015 SHALL update HI/LO at the FIX-exit edge, and SHALL assert done=1 with busy=0 for exactly the following cycle.
REQ-016 SHALL accept a new start in the done cycle.
REQ-017 MULT SHALL perform a radix-2 shift-add on operand magnitudes and apply sign correction in FIX, giving {HI,LO} = the full 64-bit product.
REQ-018 DIV SHALL perform restoring division on magnitudes, giving LO=quotient truncated toward zero and HI=remainder with the dividend's sign.
REQ-019 Divide by zero SHALL give HI=A and LO=0xFFFFFFFF, with normal 33-cycle timing.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-021 HI and LO SHALL hold their values in every cycle except the writes defined above.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE and HI=LO=0, busy=0, done=0, clearing all internal datapath registers.
REQ-023 Reset mid-operation SHALL abort the operation with no done pulse; the first start is accepted on the first edge after rst_n rises.

Configuration
REQ-024 Macro MDU_DIV_EN defined: the divider datapath and DIV behaviour SHALL be exactly as in REQ-018 to REQ-020.
REQ-025 Macro MDU_DIV_EN undefined: the divider logic SHALL be absent; an accepted DIV SHALL leave HI/LO unchanged, keep busy=0, and pulse done in the next cycle.

Verification
REQ-026 Signed MULT with A=0xFFFFFFFD, B=7: busy for 33 cycles, then done with HI=0xFFFFFFFF and LO=0xFFFFFFEB.
REQ-027 Unsigned MULT with A=B=0xFFFFFFFF gives HI=0xFFFFFFFE and LO=0x00000001.
REQ-028 Signed DIV with A=0xFFFFFFF9 (-7), B=2 gives LO=0xFFFFFFFD and HI=0xFFFFFFFF; unsigned DIV with A=7, B=0 gives HI=7 and LO=0xFFFFFFFF.
REQ-029 With MULT running, assert start for DIV and for MTHI at cycle 5: both are ignored, and the final HI/LO equal the MULT result only.
REQ-030 Drive rst_n low at cycle 10 of a MULT: busy, done, HI and LO go to 0 immediately, and no done pulse ever follows.
REQ-031 Build without MDU_DIV_EN and issue DIV with A=9, B=3 after MTLO with A=0x55: LO stays 0x55 and done pulses in the next cycle.
